// File: rtl/gshare_branch_predictor.sv
// gshare branch direction predictor: PHT of saturating counters indexed by
// PC ^ speculative global history, registered prediction, resolve-time
// training and history repair on mispredict. GHR_W = 0 gives a bimodal table.

// One PHT entry: a CTR_W-bit saturating counter. It also exposes the value it
// would take if trained this cycle so the top level can bypass it to a lookup.
module gshare_ctr_cell #(
    parameter int unsigned      CTR_W   = 2,
    parameter logic [CTR_W-1:0] RST_CTR = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_en_i,
    input  logic             up_taken_i,
    output logic [CTR_W-1:0] ctr_o,
    output logic [CTR_W-1:0] ctr_nxt_o
);
    localparam logic [CTR_W-1:0] CTR_MAX = '1;

    logic [CTR_W-1:0] ctr_q;

    // Saturating step toward the resolved direction; never wraps.
    always_comb begin
        ctr_nxt_o = ctr_q;
        if (up_taken_i) begin
            if (ctr_q != CTR_MAX) ctr_nxt_o = ctr_q + 1'b1;
        end else begin
            if (ctr_q != '0) ctr_nxt_o = ctr_q - 1'b1;
        end
    end

    // Counter state, trained only when this entry is addressed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          ctr_q <= RST_CTR;
        else if (up_en_i) ctr_q <= ctr_nxt_o;
    end

    assign ctr_o = ctr_q;
endmodule

module gshare_branch_predictor #(
    parameter int unsigned CTR_W   = 2,
    parameter int unsigned IDX_W   = 6,
    parameter int unsigned GHR_W   = 6,
    parameter int unsigned RST_CTR = (1 << (CTR_W - 1)) - 1,
    localparam int unsigned GW     = (GHR_W > 0) ? GHR_W : 1
) (
    input  logic             clk,
    input  logic             rst,
    // lookup (fetch)
    input  logic             lk_valid,
    input  logic [31:0]      lk_pc,
    output logic             pr_valid,
    output logic             pr_taken,
    output logic [IDX_W-1:0] pr_idx,
    output logic [GW-1:0]    pr_ghr,
    // resolve (execute)
    input  logic             up_valid,
    input  logic [IDX_W-1:0] up_idx,
    input  logic             up_taken,
    input  logic             up_mispredict,
    input  logic [GW-1:0]    up_ghr
);
    localparam int unsigned DEPTH = 1 << IDX_W;

    logic [DEPTH-1:0][CTR_W-1:0] ctr;
    logic [DEPTH-1:0][CTR_W-1:0] ctr_nxt;

    logic [GW-1:0]    ghr_q;
    logic [IDX_W-1:0] ghr_ext;
    logic [IDX_W-1:0] lk_idx;
    logic [CTR_W-1:0] lk_ctr;
    logic             lk_pred;

    logic             pr_valid_q;
    logic             pr_taken_q;
    logic [IDX_W-1:0] pr_idx_q;
    logic [GW-1:0]    pr_ghr_q;

    // Only the word-aligned index bits of the PC feed the hash.
    logic unused_pc;
    assign unused_pc = ^{lk_pc[31:IDX_W+2], lk_pc[1:0]};

    // ------------------------------------------------------------------
    // Pattern history table
    // ------------------------------------------------------------------
    for (genvar e = 0; e < DEPTH; e++) begin : g_ent
        gshare_ctr_cell #(
            .CTR_W   (CTR_W),
            .RST_CTR (CTR_W'(RST_CTR))
        ) u_cell (
            .clk        (clk),
            .rst        (rst),
            .up_en_i    (up_valid && (up_idx == IDX_W'(e))),
            .up_taken_i (up_taken),
            .ctr_o      (ctr[e]),
            .ctr_nxt_o  (ctr_nxt[e])
        );
    end

    // ------------------------------------------------------------------
    // Lookup: hash with pre-edge history, bypass a same-cycle update so the
    // prediction never sees a stale counter.
    // ------------------------------------------------------------------
    assign ghr_ext = IDX_W'(ghr_q);
    assign lk_idx  = lk_pc[IDX_W+1:2] ^ ghr_ext;
    assign lk_ctr  = (up_valid && (up_idx == lk_idx)) ? ctr_nxt[up_idx] : ctr[lk_idx];
    assign lk_pred = lk_ctr[CTR_W-1];

    // ------------------------------------------------------------------
    // Global history register
    // ------------------------------------------------------------------
    if (GHR_W == 0) begin : g_no_ghr
        // Bimodal: no history, nothing to repair.
        logic unused_ghr;
        assign unused_ghr = ^{up_ghr, up_mispredict, lk_pred};
        assign ghr_q      = '0;
    end else begin : g_ghr
        logic [GW-1:0] ghr_d;
        logic [GW-1:0] ghr_spec;
        logic [GW-1:0] ghr_rec;

        if (GHR_W == 1) begin : g_w1
            logic unused_up_ghr;
            assign unused_up_ghr = up_ghr[0];
            assign ghr_spec      = lk_pred;
            assign ghr_rec       = up_taken;
        end else begin : g_wn
            // The oldest snapshot bit falls off the end on repair.
            logic unused_up_ghr;
            assign unused_up_ghr = up_ghr[GW-1];
            assign ghr_spec      = {ghr_q[GW-2:0], lk_pred};
            assign ghr_rec       = {up_ghr[GW-2:0], up_taken};
        end

        // Repair from the resolved branch wins over the speculative shift.
        always_comb begin
            ghr_d = ghr_q;
            if (up_valid && up_mispredict) ghr_d = ghr_rec;
            else if (lk_valid)             ghr_d = ghr_spec;
        end

        // History state.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) ghr_q <= '0;
            else     ghr_q <= ghr_d;
        end
    end

    // ------------------------------------------------------------------
    // Registered prediction; payload holds while no lookup is issued.
    // ------------------------------------------------------------------
    // Prediction output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pr_valid_q <= 1'b0;
            pr_taken_q <= 1'b0;
            pr_idx_q   <= '0;
            pr_ghr_q   <= '0;
        end else begin
            pr_valid_q <= lk_valid;
            if (lk_valid) begin
                pr_taken_q <= lk_pred;
                pr_idx_q   <= lk_idx;
                pr_ghr_q   <= ghr_q;
            end
        end
    end

    assign pr_valid = pr_valid_q;
    assign pr_taken = pr_taken_q;
    assign pr_idx   = pr_idx_q;
    assign pr_ghr   = pr_ghr_q;
endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Bench for gshare_branch_predictor at default parameters (CTR_W=2, IDX_W=6,
// GHR_W=6). Cycle vectors carry hand-derived expectations; lookups push the
// expected prediction to a scoreboard that is popped when the DUT responds.
module tb_gshare_branch_predictor;
    logic        clk = 1'b0;
    logic        rst;
    logic        lk_valid;
    logic [31:0] lk_pc;
    logic        pr_valid;
    logic        pr_taken;
    logic [5:0]  pr_idx;
    logic [5:0]  pr_ghr;
    logic        up_valid;
    logic [5:0]  up_idx;
    logic        up_taken;
    logic        up_mispredict;
    logic [5:0]  up_ghr;

    gshare_branch_predictor dut (
        .clk           (clk),
        .rst           (rst),
        .lk_valid      (lk_valid),
        .lk_pc         (lk_pc),
        .pr_valid      (pr_valid),
        .pr_taken      (pr_taken),
        .pr_idx        (pr_idx),
        .pr_ghr        (pr_ghr),
        .up_valid      (up_valid),
        .up_idx        (up_idx),
        .up_taken      (up_taken),
        .up_mispredict (up_mispredict),
        .up_ghr        (up_ghr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        lk_v;
        logic [31:0] pc;
        logic        up_v;
        logic [5:0]  uidx;
        logic        ut;
        logic        um;
        logic [5:0]  ughr;
        logic        et;
        logic [5:0]  eidx;
        logic [5:0]  eghr;
    } vec_t;

    typedef struct {
        logic       t;
        logic [5:0] idx;
        logic [5:0] ghr;
    } exp_t;

    exp_t       sb[$];
    vec_t       vecs[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [5:0] last_idx = '0;

    function automatic vec_t mk(input logic lk_v, input logic [31:0] pc,
                                input logic up_v, input logic [5:0] uidx,
                                input logic ut, input logic um, input logic [5:0] ughr,
                                input logic et, input logic [5:0] eidx, input logic [5:0] eghr);
        vec_t v;
        v.lk_v = lk_v; v.pc = pc; v.up_v = up_v; v.uidx = uidx; v.ut = ut;
        v.um = um; v.ughr = ughr; v.et = et; v.eidx = eidx; v.eghr = eghr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle, push the expected prediction, then compare after the edge.
    task automatic step(input vec_t v, input string tag);
        exp_t e;
        lk_valid      = v.lk_v;
        lk_pc         = v.pc;
        up_valid      = v.up_v;
        up_idx        = v.uidx;
        up_taken      = v.ut;
        up_mispredict = v.um;
        up_ghr        = v.ughr;
        if (v.lk_v) begin
            e.t = v.et; e.idx = v.eidx; e.ghr = v.eghr;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        lk_valid = 1'b0; up_valid = 1'b0; up_mispredict = 1'b0;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, ".valid"}, 32'(pr_valid), 32'd1);
            chk({tag, ".taken"}, 32'(pr_taken), 32'(e.t));
            chk({tag, ".idx"},   32'(pr_idx),   32'(e.idx));
            chk({tag, ".ghr"},   32'(pr_ghr),   32'(e.ghr));
            last_idx = e.idx;
        end else begin
            chk({tag, ".idle_valid"}, 32'(pr_valid), 32'd0);
            chk({tag, ".hold_idx"},   32'(pr_idx),   32'(last_idx));
        end
    endtask

    initial begin
        rst = 1'b1; lk_valid = 0; lk_pc = 0; up_valid = 0; up_idx = 0;
        up_taken = 0; up_mispredict = 0; up_ghr = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.valid", 32'(pr_valid), 32'd0);
        chk("rst.taken", 32'(pr_taken), 32'd0);
        chk("rst.idx",   32'(pr_idx),   32'd0);
        chk("rst.ghr",   32'(pr_ghr),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        //                 lk  pc     upv uidx ut um ughr   et eidx  eghr
        vecs.push_back(mk(1, 32'h100, 0, 0,  0, 0, 0,     0, 6'h00, 6'h00)); // 0 first lookup
        vecs.push_back(mk(0, 0,       1, 5,  1, 0, 0,     0, 0, 0));         // 1 ctr5 1->2
        vecs.push_back(mk(0, 0,       1, 5,  1, 0, 0,     0, 0, 0));         // 2 ctr5 ->3
        vecs.push_back(mk(0, 0,       1, 5,  1, 0, 0,     0, 0, 0));         // 3 ctr5 sat 3
        vecs.push_back(mk(1, 32'h14,  0, 0,  0, 0, 0,     1, 6'h05, 6'h00)); // 4 idx5 taken
        vecs.push_back(mk(0, 0,       1, 5,  0, 0, 0,     0, 0, 0));         // 5 ctr5 ->2
        vecs.push_back(mk(0, 0,       1, 5,  0, 0, 0,     0, 0, 0));         // 6 ->1
        vecs.push_back(mk(0, 0,       1, 5,  0, 0, 0,     0, 0, 0));         // 7 ->0
        vecs.push_back(mk(0, 0,       1, 5,  0, 0, 0,     0, 0, 0));         // 8 sat 0
        vecs.push_back(mk(1, 32'h10,  0, 0,  0, 0, 0,     0, 6'h05, 6'h01)); // 9 idx5 not taken
        vecs.push_back(mk(1, 32'h2C,  1, 9,  1, 0, 0,     1, 6'h09, 6'h02)); // 10 bypass
        vecs.push_back(mk(1, 32'h30,  0, 0,  0, 0, 0,     1, 6'h09, 6'h05)); // 11 ctr9 = 2
        vecs.push_back(mk(0, 0,       1, 9,  0, 0, 0,     0, 0, 0));         // 12 ctr9 ->1
        vecs.push_back(mk(1, 32'h08,  0, 0,  0, 0, 0,     0, 6'h09, 6'h0B)); // 13 ctr9 = 1
        vecs.push_back(mk(0, 0,       1, 20, 1, 0, 0,     0, 0, 0));         // 14 ctr20 ->2
        vecs.push_back(mk(0, 0,       1, 63, 0, 1, 6'h00, 0, 0, 0));         // 15 repair GHR=0
        vecs.push_back(mk(1, 32'h50,  0, 0,  0, 0, 0,     1, 6'h14, 6'h00)); // 16 pred 1
        vecs.push_back(mk(1, 32'h04,  0, 0,  0, 0, 0,     0, 6'h00, 6'h01)); // 17 pred 0
        vecs.push_back(mk(1, 32'h58,  0, 0,  0, 0, 0,     1, 6'h14, 6'h02)); // 18 pred 1
        vecs.push_back(mk(1, 32'h0C,  0, 0,  0, 0, 0,     0, 6'h06, 6'h05)); // 19 GHR=000101
        vecs.push_back(mk(1, 32'h00,  1, 40, 1, 1, 6'h2A, 0, 6'h0A, 6'h0A)); // 20 repair + lookup
        vecs.push_back(mk(1, 32'h00,  0, 0,  0, 0, 0,     0, 6'h15, 6'h15)); // 21 GHR=010101
        vecs.push_back(mk(1, 32'h08,  0, 0,  0, 0, 0,     1, 6'h28, 6'h2A)); // 22 ctr40 = 2
        vecs.push_back(mk(0, 0,       0, 0,  0, 1, 6'h3F, 0, 0, 0));         // 23 unqualified mispredict
        vecs.push_back(mk(1, 32'h00,  0, 0,  0, 0, 0,     0, 6'h15, 6'h15)); // 24 GHR untouched

        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i], $sformatf("v%0d", i));

        // Reset while a prediction is being presented.
        step(mk(1, 32'h08, 0, 0, 0, 0, 0, 1, 6'h28, 6'h2A), "pre_rst");
        rst = 1'b1;
        #1;
        chk("midrst.valid", 32'(pr_valid), 32'd0);
        chk("midrst.taken", 32'(pr_taken), 32'd0);
        chk("midrst.idx",   32'(pr_idx),   32'd0);
        chk("midrst.ghr",   32'(pr_ghr),   32'd0);
        sb.delete();
        last_idx = '0;
        @(negedge clk);
        rst = 1'b0;
        // Trained entries are back to weakly not-taken and history is zero.
        step(mk(1, 32'h50, 0, 0, 0, 0, 0, 0, 6'h14, 6'h00), "post_rst20");
        step(mk(1, 32'hA0, 0, 0, 0, 0, 0, 0, 6'h28, 6'h00), "post_rst40");
        step(mk(1, 32'h14, 0, 0, 0, 0, 0, 0, 6'h05, 6'h00), "post_rst5");
        step(mk(0, 0,      0, 0, 0, 0, 0, 0, 0, 0),         "post_rst_idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
